// File: rtl/chan_packet_thresh_loader_if.sv
// Bus bundle between the load_thresh register / trigger datapath and the threshold loader.
// The master drives the register word and read requests; the slave returns thresholds and status.
interface chan_packet_thresh_loader_if #(
    parameter int CHAN_W   = 8,
    parameter int THRESH_W = 16
);
    logic [31:0]         load_thresh_reg;
    logic [CHAN_W-1:0]   chan_in;
    logic                chan_valid;
    logic [THRESH_W-1:0] thresh_out;
    logic [CHAN_W-1:0]   chan_out;
    logic                thresh_valid;
    logic                init_done;
    logic                load_ack;
    logic [15:0]         load_count;

    modport master (
        output load_thresh_reg, chan_in, chan_valid,
        input  thresh_out, chan_out, thresh_valid, init_done, load_ack, load_count
    );

    modport slave (
        input  load_thresh_reg, chan_in, chan_valid,
        output thresh_out, chan_out, thresh_valid, init_done, load_ack, load_count
    );
endinterface

// File: rtl/chan_packet_thresh_loader.sv
// Per-channel trigger threshold table: clears itself after reset, accepts qualified software
// loads from the load_thresh word, and serves thresholds to the datapath with 2-cycle latency.
module chan_packet_thresh_loader #(
    parameter int                  N_CHAN         = 256,
    parameter int                  CHAN_W         = 8,
    parameter int                  THRESH_W       = 16,
    parameter int                  STABLE_CYC     = 4,
    parameter logic [THRESH_W-1:0] DEFAULT_THRESH = THRESH_W'(16'h7FFF)
) (
    input  logic                         user_clk,
    input  logic                         user_rst,
    chan_packet_thresh_loader_if.slave   s_bus
);

    localparam int                QCNT_W    = $clog2(STABLE_CYC + 1);
    localparam logic [CHAN_W-1:0] LAST_ADDR = CHAN_W'(N_CHAN - 1);
    localparam logic [CHAN_W:0]   N_CHAN_L  = (CHAN_W + 1)'(N_CHAN);

    typedef enum logic [2:0] {
        S_CLEAR    = 3'd0,
        S_WAIT_LOW = 3'd1,
        S_IDLE     = 3'd2,
        S_QUAL     = 3'd3,
        S_WRITE    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CHAN_W-1:0]   r_clr_addr;
    logic [CHAN_W-1:0]   w_clr_addr_nxt;
    logic [31:0]         r_word;
    logic [31:0]         w_word_nxt;
    logic [QCNT_W-1:0]   r_qcnt;
    logic [QCNT_W-1:0]   w_qcnt_nxt;
    logic                r_init_done;
    logic                w_init_done_nxt;
    logic                r_load_ack;
    logic                w_load_ack_nxt;
    logic [15:0]         r_load_count;
    logic [15:0]         w_load_count_nxt;

    logic                w_we;
    logic [CHAN_W-1:0]   w_waddr;
    logic [THRESH_W-1:0] w_wdata;

    logic                w_load_bit;
    logic [CHAN_W-1:0]   w_cap_chan;
    logic [THRESH_W-1:0] w_cap_thresh;
    logic                w_cap_in_range;

    logic [THRESH_W-1:0] r_table [0:N_CHAN-1];

    logic [CHAN_W-1:0]   r_s1_chan;
    logic                r_s1_valid;
    logic                r_s1_init;
    logic                w_s1_in_range;
    logic [THRESH_W-1:0] r_thresh_out;
    logic [CHAN_W-1:0]   r_chan_out;
    logic                r_thresh_valid;

    assign w_load_bit     = s_bus.load_thresh_reg[31];
    assign w_cap_chan     = r_word[CHAN_W+15:16];
    assign w_cap_thresh   = r_word[THRESH_W-1:0];
    assign w_cap_in_range = ({1'b0, w_cap_chan} < N_CHAN_L);
    assign w_s1_in_range  = ({1'b0, r_s1_chan} < N_CHAN_L);

    // Control state and counters.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_state      <= S_CLEAR;
            r_clr_addr   <= {CHAN_W{1'b0}};
            r_word       <= 32'd0;
            r_qcnt       <= {QCNT_W{1'b0}};
            r_init_done  <= 1'b0;
            r_load_ack   <= 1'b0;
            r_load_count <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_addr   <= w_clr_addr_nxt;
            r_word       <= w_word_nxt;
            r_qcnt       <= w_qcnt_nxt;
            r_init_done  <= w_init_done_nxt;
            r_load_ack   <= w_load_ack_nxt;
            r_load_count <= w_load_count_nxt;
        end
    end

    // Next-state, table write port and load bookkeeping.
    always_comb begin
        w_state_nxt      = r_state;
        w_clr_addr_nxt   = r_clr_addr;
        w_word_nxt       = r_word;
        w_qcnt_nxt       = r_qcnt;
        w_init_done_nxt  = r_init_done;
        w_load_ack_nxt   = 1'b0;
        w_load_count_nxt = r_load_count;
        w_we             = 1'b0;
        w_waddr          = r_clr_addr;
        w_wdata          = DEFAULT_THRESH;

        case (r_state)
            S_CLEAR: begin
                w_we = 1'b1;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt     = S_WAIT_LOW;
                    w_init_done_nxt = 1'b1;
                    w_clr_addr_nxt  = {CHAN_W{1'b0}};
                end else begin
                    w_clr_addr_nxt  = r_clr_addr + CHAN_W'(1);
                end
            end
            S_WAIT_LOW: begin
                // A load bit still high from before must drop before a new command counts.
                if (!w_load_bit) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_LOW;
                end
            end
            S_IDLE: begin
                if (w_load_bit) begin
                    w_word_nxt  = s_bus.load_thresh_reg;
                    w_qcnt_nxt  = QCNT_W'(1);
                    w_state_nxt = S_QUAL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_QUAL: begin
                if (!w_load_bit) begin
                    w_state_nxt = S_IDLE;
                end else if (s_bus.load_thresh_reg != r_word) begin
                    w_word_nxt  = s_bus.load_thresh_reg;
                    w_qcnt_nxt  = QCNT_W'(1);
                end else if (r_qcnt == QCNT_W'(STABLE_CYC)) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_qcnt_nxt  = r_qcnt + QCNT_W'(1);
                end
            end
            S_WRITE: begin
                w_state_nxt = S_WAIT_LOW;
                if (w_cap_in_range) begin
                    w_we             = 1'b1;
                    w_waddr          = w_cap_chan;
                    w_wdata          = w_cap_thresh;
                    w_load_ack_nxt   = 1'b1;
                    w_load_count_nxt = r_load_count + 16'd1;
                end else begin
                    w_we             = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // Threshold table storage; contents are defined by the post-reset clear, not by reset.
    always_ff @(posedge user_clk) begin
        if (w_we) begin
            r_table[w_waddr] <= w_wdata;
        end
    end

    // Two-stage read pipeline; a same-cycle write to the read address yields the old value.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_s1_chan      <= {CHAN_W{1'b0}};
            r_s1_valid     <= 1'b0;
            r_s1_init      <= 1'b0;
            r_thresh_out   <= {THRESH_W{1'b0}};
            r_chan_out     <= {CHAN_W{1'b0}};
            r_thresh_valid <= 1'b0;
        end else begin
            r_s1_chan      <= s_bus.chan_in;
            r_s1_valid     <= s_bus.chan_valid;
            r_s1_init      <= r_init_done;
            r_chan_out     <= r_s1_chan;
            r_thresh_valid <= r_s1_valid;
            if (r_s1_init && w_s1_in_range) begin
                r_thresh_out <= r_table[r_s1_chan];
            end else begin
                r_thresh_out <= DEFAULT_THRESH;
            end
        end
    end

    assign s_bus.thresh_out   = r_thresh_out;
    assign s_bus.chan_out     = r_chan_out;
    assign s_bus.thresh_valid = r_thresh_valid;
    assign s_bus.init_done    = r_init_done;
    assign s_bus.load_ack     = r_load_ack;
    assign s_bus.load_count   = r_load_count;

endmodule
